// File: rtl/ps2_key_fifo.sv
// PS/2 set-2 scan-code decoder with Shift tracking, ASCII mapping and a show-ahead character FIFO.
// Optional build macro PS2_TYPEMATIC_FILTER_EN drops auto-repeat makes of a key that is still held.
module ps2_key_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic [7:0]       code,
  input  logic             rd_en,
  output logic [7:0]       ascii,
  output logic             ascii_valid,
  output logic             fifo_full,
  output logic             overflow,
  output logic             shift_held,
  output logic [CNT_W-1:0] key_count,
  output logic [7:0]       last_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_OCC = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

  state_t           state_reg, state_next;
  logic             make_evt, brk_evt;
  logic             lshift_reg, rshift_reg;
  logic [7:0]       last_code_reg;
  logic             overflow_reg;
  logic [CNT_W-1:0] key_count_reg;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [OW-1:0]    occ_reg;
  logic [7:0]       mem [FIFO_DEPTH];

  logic             map_hit, map_letter;
  logic [7:0]       map_base, map_char;
  logic             repeat_hit, push_req, push_ok, pop_ok, full, empty;

  // ---------------- prefix FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (code_valid) begin
      case (state_reg)
        ST_IDLE: begin
          if (code == 8'hF0)      state_next = ST_BRK;
          else if (code == 8'hE0) state_next = ST_EXT;
          else                    state_next = ST_IDLE;
        end
        ST_BRK:     state_next = ST_IDLE;
        ST_EXT:     state_next = (code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    make_evt = 1'b0;
    brk_evt  = 1'b0;
    if (code_valid) begin
      case (state_reg)
        ST_IDLE: make_evt = (code != 8'hF0) && (code != 8'hE0);
        ST_BRK:  brk_evt  = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- scan-code to ASCII map ----------------
  // Letters are stored lower-case; Shift clears bit 5 to get upper-case.
  always_comb begin
    map_hit    = 1'b1;
    map_letter = 1'b0;
    map_base   = 8'h00;
    case (code)
      8'h45: map_base = 8'h30;
      8'h16: map_base = 8'h31;
      8'h1E: map_base = 8'h32;
      8'h26: map_base = 8'h33;
      8'h25: map_base = 8'h34;
      8'h2E: map_base = 8'h35;
      8'h36: map_base = 8'h36;
      8'h3D: map_base = 8'h37;
      8'h3E: map_base = 8'h38;
      8'h46: map_base = 8'h39;
      8'h29: map_base = 8'h20;
      8'h5A: map_base = 8'h0D;
      8'h1C: begin map_base = 8'h61; map_letter = 1'b1; end
      8'h32: begin map_base = 8'h62; map_letter = 1'b1; end
      8'h21: begin map_base = 8'h63; map_letter = 1'b1; end
      8'h23: begin map_base = 8'h64; map_letter = 1'b1; end
      8'h24: begin map_base = 8'h65; map_letter = 1'b1; end
      8'h2B: begin map_base = 8'h66; map_letter = 1'b1; end
      8'h34: begin map_base = 8'h67; map_letter = 1'b1; end
      8'h33: begin map_base = 8'h68; map_letter = 1'b1; end
      8'h43: begin map_base = 8'h69; map_letter = 1'b1; end
      8'h3B: begin map_base = 8'h6A; map_letter = 1'b1; end
      8'h42: begin map_base = 8'h6B; map_letter = 1'b1; end
      8'h4B: begin map_base = 8'h6C; map_letter = 1'b1; end
      8'h3A: begin map_base = 8'h6D; map_letter = 1'b1; end
      8'h31: begin map_base = 8'h6E; map_letter = 1'b1; end
      8'h44: begin map_base = 8'h6F; map_letter = 1'b1; end
      8'h4D: begin map_base = 8'h70; map_letter = 1'b1; end
      8'h15: begin map_base = 8'h71; map_letter = 1'b1; end
      8'h2D: begin map_base = 8'h72; map_letter = 1'b1; end
      8'h1B: begin map_base = 8'h73; map_letter = 1'b1; end
      8'h2C: begin map_base = 8'h74; map_letter = 1'b1; end
      8'h3C: begin map_base = 8'h75; map_letter = 1'b1; end
      8'h2A: begin map_base = 8'h76; map_letter = 1'b1; end
      8'h1D: begin map_base = 8'h77; map_letter = 1'b1; end
      8'h22: begin map_base = 8'h78; map_letter = 1'b1; end
      8'h35: begin map_base = 8'h79; map_letter = 1'b1; end
      8'h1A: begin map_base = 8'h7A; map_letter = 1'b1; end
      default: map_hit = 1'b0;
    endcase
    map_char = (map_letter && shift_held) ? (map_base & 8'hDF) : map_base;
  end

  // ---------------- Shift and last-code tracking ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lshift_reg    <= 1'b0;
      rshift_reg    <= 1'b0;
      last_code_reg <= 8'h00;
    end else begin
      if (code_valid) last_code_reg <= code;
      if (make_evt && code == 8'h12) lshift_reg <= 1'b1;
      if (brk_evt  && code == 8'h12) lshift_reg <= 1'b0;
      if (make_evt && code == 8'h59) rshift_reg <= 1'b1;
      if (brk_evt  && code == 8'h59) rshift_reg <= 1'b0;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // 0x00 is never a mapped code, so it doubles as "no key held".
  logic [7:0] filt_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 filt_reg <= 8'h00;
    else if (make_evt && map_hit)            filt_reg <= code;
    else if (brk_evt && code == filt_reg)    filt_reg <= 8'h00;
  end
  assign repeat_hit = (filt_reg != 8'h00) && (code == filt_reg);
`else
  assign repeat_hit = 1'b0;
`endif

  // ---------------- FIFO ----------------
  assign full     = (occ_reg == DEPTH_OCC);
  assign empty    = (occ_reg == '0);
  assign push_req = make_evt && map_hit && !repeat_hit;
  assign pop_ok   = rd_en && !empty;
  assign push_ok  = push_req && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= map_char;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      occ_reg       <= '0;
      overflow_reg  <= 1'b0;
      key_count_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg    <= wr_ptr_reg + 1'b1;
        key_count_reg <= key_count_reg + 1'b1;
      end
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      occ_reg <= occ_reg + 1'b1;
      else if (!push_ok && pop_ok) occ_reg <= occ_reg - 1'b1;
      if (push_req && !push_ok) overflow_reg <= 1'b1;
    end
  end

  assign ascii       = empty ? 8'h00 : mem[rd_ptr_reg];
  assign ascii_valid = !empty;
  assign fifo_full   = full;
  assign overflow    = overflow_reg;
  assign shift_held  = lshift_reg | rshift_reg;
  assign key_count   = key_count_reg;
  assign last_code   = last_code_reg;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: decoding, Shift, prefixes, FIFO full/overflow, reset abort.
module tb_ps2_key_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid;
  logic [7:0]  code;
  logic        rd_en;
  logic [7:0]  ascii;
  logic        ascii_valid;
  logic        fifo_full;
  logic        overflow;
  logic        shift_held;
  logic [15:0] key_count;
  logic [7:0]  last_code;

  int tests_run = 0;
  int tests_failed = 0;

  ps2_key_fifo #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code), .rd_en(rd_en),
    .ascii(ascii), .ascii_valid(ascii_valid), .fifo_full(fifo_full),
    .overflow(overflow), .shift_held(shift_held), .key_count(key_count),
    .last_code(last_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code = b; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic send_rd(input logic [7:0] b);
    @(negedge clk);
    code = b; code_valid = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, ascii_valid}, 32'd1);
    check(tag, {24'd0, ascii}, {24'd0, exp});
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] fill_codes [9];
  logic [7:0] fill_chars [9];

  initial begin
    fill_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    fill_chars = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
    rst = 1'b1; code_valid = 1'b0; code = 8'h00; rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ascii", {24'd0, ascii}, 32'h00);
    check("rst_valid", {31'd0, ascii_valid}, 32'd0);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_shift", {31'd0, shift_held}, 32'd0);
    check("rst_count", {16'd0, key_count}, 32'd0);
    check("rst_last", {24'd0, last_code}, 32'h00);

    // Single key press/release
    send(8'h1C);
    check("a_visible", {24'd0, ascii}, 32'h61);
    send(8'hF0); send(8'h1C);
    check("a_valid", {31'd0, ascii_valid}, 32'd1);
    check("a_ascii", {24'd0, ascii}, 32'h61);
    check("a_count", {16'd0, key_count}, 32'd1);
    check("a_last", {24'd0, last_code}, 32'h1C);
    @(negedge clk); rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    check("a_pop_valid", {31'd0, ascii_valid}, 32'd0);
    check("a_pop_ascii", {24'd0, ascii}, 32'h00);

    // Shift handling
    send(8'h12);
    check("shift_on", {31'd0, shift_held}, 32'd1);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    check("shift_off", {31'd0, shift_held}, 32'd0);
    send(8'h1C);
    check("shift_count", {16'd0, key_count}, 32'd3);
    pop_expect("shift_A", 8'h41);
    pop_expect("shift_a", 8'h61);
    check("shift_empty", {31'd0, ascii_valid}, 32'd0);

    // Right shift on a digit, space, enter, unmapped
    send(8'h59); send(8'h45); send(8'hF0); send(8'h59);
    send(8'h29); send(8'h5A); send(8'h76);
    check("misc_count", {16'd0, key_count}, 32'd6);
    pop_expect("digit_shift", 8'h30);
    pop_expect("space", 8'h20);
    pop_expect("enter", 8'h0D);
    check("misc_empty", {31'd0, ascii_valid}, 32'd0);

    // Extended prefixes discarded
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h0E);
    check("ext_empty", {31'd0, ascii_valid}, 32'd0);
    check("ext_last", {24'd0, last_code}, 32'h0E);
    check("ext_count", {16'd0, key_count}, 32'd6);
    send(8'h1C);
    pop_expect("ext_idle", 8'h61);

    // Fill past capacity without reads
    do_reset();
    for (int i = 0; i < 8; i++) send(fill_codes[i]);
    check("fill_full", {31'd0, fifo_full}, 32'd1);
    check("fill_noovf", {31'd0, overflow}, 32'd0);
    send(fill_codes[8]);
    check("fill_ovf", {31'd0, overflow}, 32'd1);
    check("fill_count", {16'd0, key_count}, 32'd8);
    for (int i = 0; i < 8; i++) pop_expect($sformatf("fill_pop%0d", i), fill_chars[i]);
    check("fill_empty", {31'd0, ascii_valid}, 32'd0);
    check("fill_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Full with simultaneous read accepts the push
    do_reset();
    for (int i = 0; i < 8; i++) send(fill_codes[i]);
    send_rd(fill_codes[8]);
    check("frd_ovf", {31'd0, overflow}, 32'd0);
    check("frd_count", {16'd0, key_count}, 32'd9);
    check("frd_full", {31'd0, fifo_full}, 32'd1);
    for (int i = 1; i < 9; i++) pop_expect($sformatf("frd_pop%0d", i), fill_chars[i]);

    // Typematic repeats
    do_reset();
    send(8'h45); send(8'h45); send(8'h45); send(8'hF0); send(8'h45);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("typ_count", {16'd0, key_count}, 32'd1);
    pop_expect("typ_0", 8'h30);
`else
    check("typ_count", {16'd0, key_count}, 32'd3);
    for (int i = 0; i < 3; i++) pop_expect($sformatf("typ_%0d", i), 8'h30);
`endif
    check("typ_empty", {31'd0, ascii_valid}, 32'd0);

    // Reset in the middle of a break sequence
    send(8'hF0);
    do_reset();
    check("abort_count", {16'd0, key_count}, 32'd0);
    send(8'h16);
    check("abort_push", {24'd0, ascii}, 32'h31);
    check("abort_valid", {31'd0, ascii_valid}, 32'd1);
    check("abort_count1", {16'd0, key_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
